picorv32_mem_arbiter: RTL and testbench

// - N-master arbiter for the PicoRV32 native memory interface (valid/ready/addr/wdata/wstrb/rdata/instr).
// - Lets several cores or DMA masters share one memory/peripheral slave port.
// - Round-robin or fixed priority, with a per-transaction timeout that completes a hung access with an error pulse.
// - Sits between the core top-level wrappers and the system memory.

---
 rtl/picorv32_mem_arbiter_pkg.sv | 31 +++
 rtl/picorv32_rr_arbiter.sv | 50 +++++
 rtl/picorv32_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_picorv32_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_mem_arbiter_pkg.sv
// Shared types and constants for the PicoRV32 native-memory arbiter and its
// arbitration core.
package picorv32_mem_arbiter_pkg;

    localparam int GRANT_W = 3;
    localparam int TCNT_W  = 16;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Everything latched from the winning master except the address, whose
    // width is a parameter of the top.
    typedef struct packed {
        logic        instr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_req_t;

    // Next search start after serving idx, wrapping at n.
    function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                   input int n);
        logic [GRANT_W:0] inc;
        inc = {1'b0, idx} + 1'b1;
        if (int'(inc) >= n) return '0;
        return inc[GRANT_W-1:0];
    endfunction

endpackage

// File: rtl/picorv32_rr_arbiter.sv
// Combinational arbiter: round-robin from a start pointer, or fixed priority
// (lowest index wins). Produces a one-hot grant and its index.
module picorv32_rr_arbiter
    import picorv32_mem_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]       req,
    input  logic [GRANT_W-1:0] ptr,
    input  logic               fixed_pri,
    output logic [N-1:0]       gnt,
    output logic [GRANT_W-1:0] idx,
    output logic               any
);

    int   start;
    int   hi;
    int   lo;
    int   win;
    logic hi_any;
    logic lo_any;

    // Two scans: lowest request at or above the start pointer, else the lowest
    // request overall (the wrap-around case).
    always_comb begin
        start  = fixed_pri ? 0 : int'(ptr);
        hi     = 0;
        lo     = 0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_any = 1'b1;
                lo     = i;
                if (i >= start) begin
                    hi_any = 1'b1;
                    hi     = i;
                end
            end
        end
        win = hi_any ? hi : lo;
        any = lo_any;
        idx = GRANT_W'(win);
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = lo_any && (i == win);
        end
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// N-master arbiter for the PicoRV32 native memory bus: one outstanding access
// at a time, optional slave-ready timeout completing with an error pulse.
module picorv32_mem_arbiter
    import picorv32_mem_arbiter_pkg::*;
#(
    parameter int          NUM_MASTERS   = 2,
    parameter int          ADDR_WIDTH    = 32,
    parameter int          PRIORITY_MODE = 0,
    parameter int          TIMEOUT       = 0,
    parameter logic [31:0] ERR_RDATA     = ERR_RDATA_DEFAULT
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_MASTERS-1:0]            m_mem_valid,
    input  logic [NUM_MASTERS-1:0]            m_mem_instr,
    output logic [NUM_MASTERS-1:0]            m_mem_ready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_mem_addr,
    input  logic [NUM_MASTERS*32-1:0]         m_mem_wdata,
    input  logic [NUM_MASTERS*4-1:0]          m_mem_wstrb,
    output logic [NUM_MASTERS*32-1:0]         m_mem_rdata,
    output logic                              s_mem_valid,
    output logic                              s_mem_instr,
    input  logic                              s_mem_ready,
    output logic [ADDR_WIDTH-1:0]             s_mem_addr,
    output logic [31:0]                       s_mem_wdata,
    output logic [3:0]                        s_mem_wstrb,
    input  logic [31:0]                       s_mem_rdata,
    output logic [GRANT_W-1:0]                grant_id,
    output logic                              err_timeout
);

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_MASTERS-1:0] arb_gnt;
    logic [GRANT_W-1:0]     arb_idx;
    logic                   arb_any;
    logic [GRANT_W-1:0]     rr_ptr;
    logic [TCNT_W-1:0]      tcnt;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    mem_req_t               sel_req;
    logic                   done_ok;
    logic                   expired;

    picorv32_rr_arbiter #(
        .N(NUM_MASTERS)
    ) u_arb (
        .req      (m_mem_valid),
        .ptr      (rr_ptr),
        .fixed_pri(PRIORITY_MODE != 0),
        .gnt      (arb_gnt),
        .idx      (arb_idx),
        .any      (arb_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_req  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (arb_gnt[i]) begin
                sel_addr      = m_mem_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_req.instr = m_mem_instr[i];
                sel_req.wstrb = m_mem_wstrb[i*4 +: 4];
                sel_req.wdata = m_mem_wdata[i*32 +: 32];
            end
        end
    end

    // A slave ready in the expiry cycle wins: the access completes normally.
    always_comb begin
        state_nxt = state;
        done_ok   = 1'b0;
        expired   = 1'b0;
        case (state)
            ST_IDLE: if (arb_any) state_nxt = ST_BUSY;
            ST_BUSY: begin
                done_ok = s_mem_ready;
                expired = !s_mem_ready && (TIMEOUT != 0) && (tcnt == TCNT_W'(TIMEOUT));
                if (done_ok || expired) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_mem_ready = '0;
        m_mem_rdata = '0;
        err_timeout = expired;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if ((done_ok || expired) && grant_id == GRANT_W'(i)) begin
                m_mem_ready[i]          = 1'b1;
                m_mem_rdata[i*32 +: 32] = done_ok ? s_mem_rdata : ERR_RDATA;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_mem_valid <= 1'b0;
            s_mem_instr <= 1'b0;
            s_mem_addr  <= '0;
            s_mem_wdata <= '0;
            s_mem_wstrb <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            tcnt        <= '0;
        end else if (state == ST_IDLE) begin
            if (arb_any) begin
                s_mem_valid <= 1'b1;
                s_mem_instr <= sel_req.instr;
                s_mem_addr  <= sel_addr;
                s_mem_wdata <= sel_req.wdata;
                s_mem_wstrb <= sel_req.wstrb;
                grant_id    <= arb_idx;
                tcnt        <= '0;
            end
        end else if (done_ok || expired) begin
            s_mem_valid <= 1'b0;
            rr_ptr      <= rr_next(grant_id, NUM_MASTERS);
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Randomized scoreboard bench for picorv32_mem_arbiter (3-master round-robin
// with timeout) plus a short fixed-priority scenario on a second instance.
module tb_picorv32_mem_arbiter;

    localparam int N  = 3;
    localparam int TO = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: round-robin, timeout
    logic [N-1:0]    a_valid, a_instr, a_ready;
    logic [N*32-1:0] a_addr, a_wdata, a_rdata;
    logic [N*4-1:0]  a_wstrb;
    logic            s_valid, s_instr, s_ready;
    logic [31:0]     s_addr, s_wdata, s_rdata;
    logic [3:0]      s_wstrb;
    logic [2:0]      a_gid;
    logic            a_err;

    // instance B: fixed priority, no timeout
    logic [N-1:0]    b_valid, b_instr, b_ready;
    logic [N*32-1:0] b_addr, b_wdata, b_rdata;
    logic [N*4-1:0]  b_wstrb;
    logic            bs_valid, bs_instr, bs_ready;
    logic [31:0]     bs_addr, bs_wdata, bs_rdata;
    logic [3:0]      bs_wstrb;
    logic [2:0]      b_gid;
    logic            b_err;

    picorv32_mem_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .PRIORITY_MODE(0),
                           .TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m_mem_valid(a_valid), .m_mem_instr(a_instr), .m_mem_ready(a_ready),
        .m_mem_addr(a_addr), .m_mem_wdata(a_wdata), .m_mem_wstrb(a_wstrb),
        .m_mem_rdata(a_rdata),
        .s_mem_valid(s_valid), .s_mem_instr(s_instr), .s_mem_ready(s_ready),
        .s_mem_addr(s_addr), .s_mem_wdata(s_wdata), .s_mem_wstrb(s_wstrb),
        .s_mem_rdata(s_rdata), .grant_id(a_gid), .err_timeout(a_err));

    picorv32_mem_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .PRIORITY_MODE(1),
                           .TIMEOUT(0), .ERR_RDATA(ERR)) dut_fp (
        .clk(clk), .resetn(resetn),
        .m_mem_valid(b_valid), .m_mem_instr(b_instr), .m_mem_ready(b_ready),
        .m_mem_addr(b_addr), .m_mem_wdata(b_wdata), .m_mem_wstrb(b_wstrb),
        .m_mem_rdata(b_rdata),
        .s_mem_valid(bs_valid), .s_mem_instr(bs_instr), .s_mem_ready(bs_ready),
        .s_mem_addr(bs_addr), .s_mem_wdata(bs_wdata), .s_mem_wstrb(bs_wstrb),
        .s_mem_rdata(bs_rdata), .grant_id(b_gid), .err_timeout(b_err));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        int          cyc;
    } slv_exp_t;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_exp_t;

    slv_exp_t slv_q[$];
    rsp_exp_t rsp_q[$];
    bit       mon_en = 1'b0;

    // Monitor: pops expectations whenever the DUT starts or completes an access.
    initial begin
        slv_exp_t    cur;
        rsp_exp_t    r;
        logic [N*32-1:0] other;
        bit          prev = 1'b0;
        cur = '{m: 0, addr: 0, wdata: 0, wstrb: 0, instr: 0, cyc: 0};
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (s_valid && !prev) begin
                    if (slv_q.size() == 0) begin
                        chk("expected grants queued", slv_q.size(), 1);
                    end else begin
                        cur = slv_q.pop_front();
                        chk("grant_id", a_gid, cur.m);
                        chk("grant cycle", cyc, cur.cyc);
                        chk("s_mem_addr", s_addr, cur.addr);
                        chk("s_mem_wdata", s_wdata, cur.wdata);
                        chk("s_mem_wstrb", s_wstrb, cur.wstrb);
                        chk("s_mem_instr", s_instr, cur.instr);
                    end
                end else if (s_valid) begin
                    chk("s_mem_addr held", s_addr, cur.addr);
                    chk("s_mem_wdata held", s_wdata, cur.wdata);
                    chk("s_mem_wstrb held", s_wstrb, cur.wstrb);
                end else if (slv_q.size() != 0 && slv_q[0].cyc < cyc) begin
                    chk("missed grant cycle", cyc, slv_q[0].cyc);
                    void'(slv_q.pop_front());
                end
                prev = s_valid;

                if (a_ready != '0) begin
                    if (rsp_q.size() == 0) begin
                        chk("expected responses queued", rsp_q.size(), 1);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("m_mem_ready", a_ready, 32'(1) << r.m);
                        chk("response cycle", cyc, r.cyc);
                        chk("m_mem_rdata", a_rdata[r.m*32 +: 32], r.rdata);
                        chk("err_timeout", a_err, r.err);
                        other = a_rdata;
                        other[r.m*32 +: 32] = '0;
                        chk("non-granted rdata zero", 32'(other != '0), 0);
                    end
                end else begin
                    chk("idle rdata zero", 32'(a_rdata != '0), 0);
                    chk("idle err_timeout", a_err, 0);
                    if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
                        chk("missed response cycle", cyc, rsp_q[0].cyc + 1);
                        void'(rsp_q.pop_front());
                    end
                end
            end
        end
    end

    // Reference model state: what each master wants, and the arbiter's rules.
    bit          pend[N];
    logic [31:0] r_addr[N], r_wdata[N];
    logic [3:0]  r_wstrb[N];
    logic        r_instr[N];
    int ptr = 0, g = 0, busy = 0, bcnt = 0, lat = 0;

    task automatic fp_test();
        int n0 = 0;
        bit bp = 1'b0;
        bit got = 1'b0;
        @(negedge clk);
        b_addr[0 +: 32]  = 32'h0000_0100;
        b_addr[64 +: 32] = 32'h0000_2000;
        bs_rdata = 32'h1234_5678;
        bs_ready = 1'b1;
        b_valid  = 3'b101;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            #2;
            if (bs_valid && !bp) begin
                chk("fp grant while m0 valid", b_gid, 0);
                chk("fp addr m0", bs_addr, 32'h100);
                n0++;
            end
            if (b_ready != '0) begin
                chk("fp ready m0", b_ready, 3'b001);
                chk("fp rdata m0", b_rdata[0 +: 32], 32'h1234_5678);
            end
            bp = bs_valid;
        end
        chk("fp m0 grant count >= 6", 32'(n0 >= 6), 1);
        @(negedge clk);
        b_valid = 3'b100;
        bp = bs_valid;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #2;
            if (bs_valid && !bp && !got) begin
                chk("fp grant after m0 drops", b_gid, 2);
                chk("fp addr m2", bs_addr, 32'h2000);
                got = 1'b1;
            end
            bp = bs_valid;
        end
        chk("fp m2 served", 32'(got), 1);
        b_valid = '0;
    endtask

    initial begin
        bit just_done;
        bit rst_pend = 1'b0;
        bit gen_en;
        int w;
        int r;
        a_valid = '0; a_instr = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        s_ready = 1'b0; s_rdata = '0;
        b_valid = '0; b_instr = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
        bs_ready = 1'b0; bs_rdata = '0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset s_mem_valid", s_valid, 0);
        chk("reset s_mem_addr", s_addr, 0);
        chk("reset s_mem_wstrb", s_wstrb, 0);
        chk("reset grant_id", a_gid, 0);
        chk("reset m_mem_ready", a_ready, 0);
        chk("reset err_timeout", a_err, 0);
        resetn = 1'b1;
        mon_en = 1'b1;

        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            just_done = 1'b0;
            gen_en = (it < 2850);
            if (it == 1000 || it == 2200) rst_pend = 1'b1;
            s_ready = 1'b0;
            s_rdata = $urandom;
            if (busy != 0) begin
                bcnt++;
                if (rst_pend && bcnt >= 2 && bcnt != lat) begin
                    // Abandon the access: no response expected, pointer back to 0.
                    resetn = 1'b0;
                    #1;
                    chk("async reset s_mem_valid", s_valid, 0);
                    chk("async reset m_mem_ready", a_ready, 0);
                    chk("async reset grant_id", a_gid, 0);
                    chk("async reset err_timeout", a_err, 0);
                    rst_pend = 1'b0;
                    busy = 0;
                    ptr = 0;
                    repeat (2) @(negedge clk);
                    resetn = 1'b1;
                end else if (bcnt == lat) begin
                    s_ready = 1'b1;
                    rsp_q.push_back('{m: g, rdata: s_rdata, err: 1'b0, cyc: cyc});
                    just_done = 1'b1;
                end else if (bcnt == TO + 1) begin
                    rsp_q.push_back('{m: g, rdata: ERR, err: 1'b1, cyc: cyc});
                    just_done = 1'b1;
                end else if ($urandom_range(15) == 0) begin
                    a_valid[g] = 1'b0;
                end
                if (just_done) begin
                    pend[g] = 1'b0;
                    a_valid[g] = 1'b0;
                    ptr = (g + 1) % N;
                    busy = 0;
                end
            end else begin
                s_ready = 1'($urandom_range(1));
            end

            for (int i = 0; i < N; i++) begin
                if (gen_en && !pend[i] && !(just_done && i == g) && $urandom_range(2) == 0) begin
                    pend[i]    = 1'b1;
                    r_addr[i]  = $urandom & 32'hFFFF_FFFC;
                    r_wdata[i] = $urandom;
                    r_wstrb[i] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
                    r_instr[i] = (r_wstrb[i] == 4'h0) ? 1'($urandom_range(1)) : 1'b0;
                    a_valid[i] = 1'b1;
                    a_instr[i] = r_instr[i];
                    a_addr[i*32 +: 32]  = r_addr[i];
                    a_wdata[i*32 +: 32] = r_wdata[i];
                    a_wstrb[i*4 +: 4]   = r_wstrb[i];
                end
            end

            if (busy == 0 && !just_done) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
                end
                if (w >= 0) begin
                    slv_q.push_back('{m: w, addr: r_addr[w], wdata: r_wdata[w],
                                      wstrb: r_wstrb[w], instr: r_instr[w], cyc: cyc + 1});
                    g = w;
                    busy = 1;
                    bcnt = 0;
                    r = $urandom_range(9);
                    if (r < 5)       lat = 1 + (r % 3);
                    else if (r < 7)  lat = TO + 1;
                    else if (r == 7) lat = TO;
                    else             lat = 1000;
                end
            end
        end
        repeat (3) @(negedge clk);
        chk("grant queue drained", slv_q.size(), 0);
        chk("response queue drained", rsp_q.size(), 0);
        mon_en = 1'b0;

        fp_test();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
